lcd_ctrl_param: RTL



---
 rtl/lcd_ctrl_param.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: image-window processor for the LCD controller path.
// Loads an IMG_W x IMG_H frame of DW-bit pixels from IROM, applies host
// commands to a movable 2x2 window, and streams the frame out to IRAM.
module lcd_ctrl_param #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] PX_ORG = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] PY_ORG = YW'(IMG_H / 2 - 1);
    localparam logic [XW-1:0] PX_MAX = XW'(IMG_W - 2);
    localparam logic [YW-1:0] PY_MAX = YW'(IMG_H - 2);
    localparam logic [AW-1:0] LAST   = AW'(N - 1);
    localparam logic [AW-1:0] ROW    = AW'(IMG_W);
    localparam logic [AW-1:0] ONE    = AW'(1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [DW-1:0] buf_r [N];
    logic [XW-1:0] px_r;
    logic [YW-1:0] py_r;
    logic [XW-1:0] px_s;
    logic [YW-1:0] py_s;
    logic [3:0]    cmd_r;

    logic [AW-1:0] a_ul_s, a_ur_s, a_ll_s, a_lr_s;
    logic [DW-1:0] p_ul_s, p_ur_s, p_ll_s, p_lr_s;
    logic [DW-1:0] n_ul_s, n_ur_s, n_ll_s, n_lr_s;
    logic [DW+1:0] sum_s;
    logic [DW-1:0] avg_s;
    logic [DW-1:0] max_a_s, max_b_s, max_s;
    logic [DW-1:0] min_a_s, min_b_s, min_s;

    // State register; reset always restarts the frame load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic for load / command / write sequencing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (IROM_A == LAST) state_s = ST_IDLE;
                else                state_s = ST_LOAD;
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == 4'd0) state_s = ST_WRITE;
                    else             state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC:  state_s = ST_IDLE;
            ST_WRITE: begin
                if (IRAM_A == LAST) state_s = ST_DONE;
                else                state_s = ST_WRITE;
            end
            ST_DONE:  state_s = ST_DONE;
            default:  state_s = ST_LOAD;
        endcase
    end

    // Row-major addresses of the four window pixels and their current values.
    always_comb begin
        a_ul_s = AW'(py_r) * ROW + AW'(px_r);
        a_ur_s = a_ul_s + ONE;
        a_ll_s = a_ul_s + ROW;
        a_lr_s = a_ll_s + ONE;
        p_ul_s = buf_r[a_ul_s];
        p_ur_s = buf_r[a_ur_s];
        p_ll_s = buf_r[a_ll_s];
        p_lr_s = buf_r[a_lr_s];
    end

    // Window reductions: the sum carries two extra bits so it never wraps.
    always_comb begin
        sum_s   = {2'b00, p_ul_s} + {2'b00, p_ur_s} + {2'b00, p_ll_s} + {2'b00, p_lr_s};
        avg_s   = DW'(sum_s >> 2);
        max_a_s = (p_ul_s > p_ur_s) ? p_ul_s : p_ur_s;
        max_b_s = (p_ll_s > p_lr_s) ? p_ll_s : p_lr_s;
        max_s   = (max_a_s > max_b_s) ? max_a_s : max_b_s;
        min_a_s = (p_ul_s < p_ur_s) ? p_ul_s : p_ur_s;
        min_b_s = (p_ll_s < p_lr_s) ? p_ll_s : p_lr_s;
        min_s   = (min_a_s < min_b_s) ? min_a_s : min_b_s;
    end

    // Command decode: new window position and new window pixel values,
    // all derived from pre-command values so the update is atomic.
    always_comb begin
        px_s   = px_r;
        py_s   = py_r;
        n_ul_s = p_ul_s;
        n_ur_s = p_ur_s;
        n_ll_s = p_ll_s;
        n_lr_s = p_lr_s;
        case (cmd_r)
            4'd1: begin
                if (py_r != {YW{1'b0}}) py_s = py_r - YW'(1);
                else                    py_s = py_r;
            end
            4'd2: begin
                if (py_r < PY_MAX) py_s = py_r + YW'(1);
                else               py_s = py_r;
            end
            4'd3: begin
                if (px_r != {XW{1'b0}}) px_s = px_r - XW'(1);
                else                    px_s = px_r;
            end
            4'd4: begin
                if (px_r < PX_MAX) px_s = px_r + XW'(1);
                else               px_s = px_r;
            end
            4'd5: begin
                n_ul_s = max_s; n_ur_s = max_s; n_ll_s = max_s; n_lr_s = max_s;
            end
            4'd6: begin
                n_ul_s = min_s; n_ur_s = min_s; n_ll_s = min_s; n_lr_s = min_s;
            end
            4'd7: begin
                n_ul_s = avg_s; n_ur_s = avg_s; n_ll_s = avg_s; n_lr_s = avg_s;
            end
            4'd8: begin
                n_ul_s = p_ur_s; n_ur_s = p_lr_s; n_lr_s = p_ll_s; n_ll_s = p_ul_s;
            end
            4'd9: begin
                n_ul_s = p_ll_s; n_ll_s = p_lr_s; n_lr_s = p_ur_s; n_ur_s = p_ul_s;
            end
            4'd10: begin
                n_ul_s = p_ll_s; n_ll_s = p_ul_s; n_ur_s = p_lr_s; n_lr_s = p_ur_s;
            end
            4'd11: begin
                n_ul_s = p_ur_s; n_ur_s = p_ul_s; n_ll_s = p_lr_s; n_lr_s = p_ll_s;
            end
            4'd12: begin
                px_s = PX_ORG;
                py_s = PY_ORG;
            end
            default: begin
                px_s = px_r;
                py_s = py_r;
            end
        endcase
    end

    // Datapath and registered outputs: frame capture, window update, frame streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            IROM_rd    <= 1'b1;
            IROM_A     <= {AW{1'b0}};
            IRAM_valid <= 1'b0;
            IRAM_A     <= {AW{1'b0}};
            IRAM_D     <= {DW{1'b0}};
            busy       <= 1'b1;
            done       <= 1'b0;
            px_r       <= PX_ORG;
            py_r       <= PY_ORG;
            cmd_r      <= 4'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    buf_r[IROM_A] <= IROM_Q;
                    if (IROM_A == LAST) begin
                        IROM_rd <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        IROM_A  <= IROM_A + ONE;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        busy  <= 1'b1;
                        cmd_r <= cmd;
                        if (cmd == 4'd0) begin
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= {AW{1'b0}};
                            IRAM_D     <= buf_r[0];
                        end
                    end
                end
                ST_EXEC: begin
                    buf_r[a_ul_s] <= n_ul_s;
                    buf_r[a_ur_s] <= n_ur_s;
                    buf_r[a_ll_s] <= n_ll_s;
                    buf_r[a_lr_s] <= n_lr_s;
                    px_r          <= px_s;
                    py_r          <= py_s;
                    busy          <= 1'b0;
                end
                ST_WRITE: begin
                    if (IRAM_A == LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        IRAM_A     <= IRAM_A + ONE;
                        IRAM_D     <= buf_r[IRAM_A + ONE];
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    busy <= 1'b1;
                end
            endcase
        end
    end

endmodule
